// File: rtl/joy_pkg.sv
// ============================================================================
//  Module   : joy_pkg
//  Purpose  : Shared button indices, default width and one-hot direction codes
//  Revision : 1.0
// ============================================================================
`default_nettype none

package joy_pkg;

    localparam int JOY_LEFT    = 0;
    localparam int JOY_RIGHT   = 1;
    localparam int JOY_UP      = 2;
    localparam int JOY_DOWN    = 3;
    localparam int JOY_NUM_BTN = 4;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_LEFT  = 4'b0001;
    localparam logic [3:0] DIR_RIGHT = 4'b0010;
    localparam logic [3:0] DIR_UP    = 4'b0100;
    localparam logic [3:0] DIR_DOWN  = 4'b1000;

    // Lowest set bit wins, so left beats right beats up beats down.
    function automatic logic [3:0] joy_resolve_dir(input logic [3:0] lvl);
        logic [3:0] r;
        r = DIR_NONE;
        if (lvl[JOY_LEFT])       r = DIR_LEFT;
        else if (lvl[JOY_RIGHT]) r = DIR_RIGHT;
        else if (lvl[JOY_UP])    r = DIR_UP;
        else if (lvl[JOY_DOWN])  r = DIR_DOWN;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/joy_debounce_bit.sv
// ============================================================================
//  Module   : joy_debounce_bit
//  Purpose  : One switch: 2-flop synchroniser, tick-based debounce, edge
//             pulses; auto-repeat on press when JOY_AUTOREPEAT_EN is defined
//  Revision : 1.0
// ============================================================================
`default_nettype none

module joy_debounce_bit #(
    parameter int DEB_TICKS    = 8
`ifdef JOY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY = 400,
    parameter int REPEAT_RATE  = 100
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = $clog2(DEB_TICKS + 1);
    localparam logic [CW-1:0] C_DEB_LAST = CW'(DEB_TICKS);

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic          w_flip;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_flip    = tick && (r_sync != r_level) && (w_cnt_inc == C_DEB_LAST);

`ifdef JOY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] C_RPT_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] C_RPT_RATE  = RW'(REPEAT_RATE);

    logic [RW-1:0] r_rpt_cnt;
    logic          r_rpt_run;
    logic [RW-1:0] w_rpt_inc;
    logic          w_rpt_fire;

    // A debounced release on this tick takes precedence over a due repeat.
    assign w_rpt_inc  = r_rpt_cnt + 1'b1;
    assign w_rpt_fire = tick && r_level && !w_flip &&
                        (w_rpt_inc == (r_rpt_run ? C_RPT_RATE : C_RPT_DELAY));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta    <= 1'b0;
            r_sync    <= 1'b0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_cnt     <= '0;
`ifdef JOY_AUTOREPEAT_EN
            r_rpt_cnt <= '0;
            r_rpt_run <= 1'b0;
`endif
        end else begin
            r_meta    <= raw;
            r_sync    <= r_meta;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (tick) begin
                if (r_sync == r_level) begin
                    r_cnt <= '0;
                end else if (w_flip) begin
                    r_cnt     <= '0;
                    r_level   <= ~r_level;
                    r_press   <= ~r_level;
                    r_release <= r_level;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
`ifdef JOY_AUTOREPEAT_EN
            if (!r_level || w_flip) begin
                r_rpt_cnt <= '0;
                r_rpt_run <= 1'b0;
            end else if (tick) begin
                if (w_rpt_fire) begin
                    r_press   <= 1'b1;
                    r_rpt_cnt <= '0;
                    r_rpt_run <= 1'b1;
                end else begin
                    r_rpt_cnt <= w_rpt_inc;
                end
            end
`endif
        end
    end

    assign level         = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;

endmodule

`default_nettype wire

// File: rtl/joy_debounce.sv
// ============================================================================
//  Module   : joy_debounce
//  Purpose  : Joystick conditioning: sample-tick divider, per-button debounce,
//             priority direction. Optional auto-repeat: JOY_AUTOREPEAT_EN
//  Revision : 1.0
// ============================================================================
`default_nettype none

module joy_debounce
    import joy_pkg::*;
#(
    parameter int NUM_BTN      = JOY_NUM_BTN,
    parameter int TICK_DIV     = 25000,
    parameter int DEB_TICKS    = 8,
    parameter int REPEAT_DELAY = 400,
    parameter int REPEAT_RATE  = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [3:0]         dir,
    output logic               tick
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] C_TICK_LAST = TW'(TICK_DIV - 1);

`ifndef JOY_AUTOREPEAT_EN
    localparam int c_unused_rpt = REPEAT_DELAY + REPEAT_RATE;
`endif

    logic [TW-1:0] r_tick_cnt;
    logic          r_tick;
    logic [3:0]    r_dir;

    // Registered strobe: first tick lands TICK_DIV cycles after reset release.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick     <= (r_tick_cnt == C_TICK_LAST);
            r_tick_cnt <= (r_tick_cnt == C_TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        joy_debounce_bit #(
            .DEB_TICKS    (DEB_TICKS)
`ifdef JOY_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
`endif
        ) u_bit (
            .clk           (clk),
            .reset         (reset),
            .tick          (r_tick),
            .raw           (btn_raw[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dir <= DIR_NONE;
        end else begin
            r_dir <= joy_resolve_dir(btn_level[JOY_DOWN:JOY_LEFT]);
        end
    end

    assign dir  = r_dir;
    assign tick = r_tick;

endmodule

`default_nettype wire

// File: doc/joy_debounce.md
Name: joy_debounce

Overview:
- Conditioning stage directly upstream of the joystick position logic.
- Takes the four raw, asynchronous, bouncing joystick switch inputs and synchronises them into clk. It then debounces them on a slow internal sample tick.
- Emits clean held levels, single-cycle press/release pulses, and a 4-way priority-resolved one-hot direction for the downstream position counter.

Parameters:
- NUM_BTN, 4, number of switch inputs; bit order {down, up, right, left}.
- TICK_DIV, 25000, clk cycles per sample tick (1 kHz at 25 MHz); must be >= 2.
- DEB_TICKS, 8, consecutive disagreeing ticks required to flip a debounced level; must be >= 1.
- REPEAT_DELAY, 400, ticks a button must stay held before auto-repeat starts (used only with the optional feature).
- REPEAT_RATE, 100, ticks between auto-repeat pulses (used only with the optional feature).

Ports:
- clk  in  1  system clock (25 MHz pixel clock domain).
- reset  in  1  synchronous, active-high.
- btn_raw  in  NUM_BTN  raw switch inputs, asynchronous, active-high.
- btn_level  out  NUM_BTN  debounced held state.
- btn_press  out  NUM_BTN  one-cycle pulse on debounced rising edge (plus repeats if enabled).
- btn_release  out  NUM_BTN  one-cycle pulse on debounced falling edge.
- dir  out  4  one-hot resolved direction {down, up, right, left}, all-zero when idle.
- tick  out  1  one-cycle sample strobe, exported for reuse.

Behaviour:
- Reset is synchronous and active-high on clk; clock is clk. Reset clears every register:
  - sync flops, tick counter, per-button counters, repeat counters;
  - all outputs = 0.
- Synchroniser: two flops per bit. The debouncer only ever sees the second-stage value sync[i].
- Tick generator:
  - counter runs 0..TICK_DIV-1, wrapping to 0;
  - tick = 1 for exactly one cycle when counter == TICK_DIV-1;
  - first tick after reset release occurs TICK_DIV cycles later.
- Per-button debounce:
  - cnt[i] has width $clog2(DEB_TICKS+1) and is evaluated only on tick.
  - sync[i] != level[i] on a tick: cnt[i]++. When the incremented value equals DEB_TICKS:
    - level[i] toggles;
    - cnt[i] clears;
    - btn_press[i] (rising) or btn_release[i] (falling) pulses in the same registered cycle.
  - sync[i] == level[i] on a tick: cnt[i] clears. Any single agreeing sample restarts the count.
  - No change on non-tick cycles.
- Latency:
  - btn_level/pulse update on the clk edge of the DEB_TICKS-th consecutive disagreeing tick;
  - raw-to-sync adds 2 cycles.
- Pulses are exactly one clk wide. They never coincide with each other for the same bit.
- dir: registered one-hot from btn_level.
  - Priority left > right > up > down: the lowest set bit wins.
  - Updates one cycle after btn_level.
  - Both left and right held → dir = 4'b0001.
- Button held through reset: after release it debounces as a fresh press. btn_press pulses after DEB_TICKS ticks.
- Reset asserted mid-count: partial counts are discarded, with no pulse.

Optional Feature:
- Macro: JOY_AUTOREPEAT_EN.
- Defined:
  - per-button repeat counter, width $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1), cleared on debounced press and whenever level[i] = 0;
  - while level[i] = 1 it counts ticks;
  - first repeat pulse on btn_press[i] at REPEAT_DELAY ticks after the press tick, then every REPEAT_RATE ticks;
  - repeat pulses align with tick and are one cycle wide;
  - release cancels any pending repeat.
- Undefined: repeat counters and logic are absent, and btn_press fires once per debounced press. REPEAT_* parameters are accepted but ignored.

Decomposition:
- Shared package joy_pkg holds:
  - button index constants JOY_LEFT = 0, JOY_RIGHT = 1, JOY_UP = 2, JOY_DOWN = 3;
  - NUM_BTN default;
  - dir one-hot encodings.
- Sub-module joy_debounce_bit, instantiated NUM_BTN times. It contains the synchroniser, debounce counter, edge pulses and optional repeat counter, and takes tick as input.
- The top level holds the tick divider and the direction resolver.

Test Plan (sim params TICK_DIV = 4, DEB_TICKS = 3, REPEAT_DELAY = 5, REPEAT_RATE = 2):
- Reset: hold reset 5 cycles, btn_raw = 0 → all outputs 0; tick first pulses 4 cycles after reset deasserts, then every 4 cycles.
- Clean press: btn_raw[0] = 1 held → btn_level[0] rises and btn_press[0] pulses for 1 cycle on the 3rd tick after sync sees 1; dir = 4'b0001 one cycle later.
- Bounce: btn_raw[2] toggles 1,0 on alternate ticks for 10 ticks → btn_level[2] stays 0 and no pulses occur. Then held 1 → press after 3 ticks.
- Release and priority:
  - hold left and right → dir = 4'b0001;
  - release left → btn_release[0] pulses after 3 ticks, and dir = 4'b0010 the cycle after.
- Reset mid-count: raise btn_raw[3], assert reset after 2 ticks, keep btn_raw[3] = 1 → no pulse during reset; press pulses 3 ticks after sync recovers post-reset.
- With JOY_AUTOREPEAT_EN: hold btn_raw[1] → initial press, then repeats at +5, +7, +9 ticks. Release → btn_release[1] pulses and repeats stop. Without the macro: a single btn_press only.
